// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the RV32I load/store funct3 codes, the responder FSM state
// encoding, and a helper that flags funct3 values the responder cannot
// execute for the given direction.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Unsigned variants only exist for loads, so a store using them is
   // treated the same as a reserved encoding.
   function automatic logic f3_illegal(input logic [2:0] funct3, input logic write);
      logic bad;
      case (funct3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = write;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for RV32I loads and stores (purely combinational).
// Ports:
//   word       in  32  current content of the addressed memory word
//   addr_lo    in  2   byte offset within the word (little-endian lanes)
//   funct3     in  3   RV32I load/store width and signedness
//   wdata      in  32  store data; low byte/halfword used for SB/SH
//   load_data  out 32  selected lane(s), sign- or zero-extended
//   store_word out 32  word with the addressed lanes replaced by wdata
//   misalign   out 1   halfword on odd address or word not 4-aligned
module mem_lane_align
   import riscv_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word,
   output logic        misalign
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Load extraction and store merge share the same lane decode; the
   // store word starts from the current word so untouched lanes survive.
   always_comb begin
      byte_sel   = word[{addr_lo, 3'b000} +: 8];
      half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
      load_data  = '0;
      store_word = word;
      misalign   = 1'b0;
      case (funct3)
         F3_B: begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
            store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         end
         F3_BU: begin
            load_data = {24'd0, byte_sel};
         end
         F3_H: begin
            load_data = {{16{half_sel[15]}}, half_sel};
            misalign  = addr_lo[0];
            if (addr_lo[1]) begin
               store_word[31:16] = wdata[15:0];
            end else begin
               store_word[15:0] = wdata[15:0];
            end
         end
         F3_HU: begin
            load_data = {16'd0, half_sel};
            misalign  = addr_lo[0];
         end
         F3_W: begin
            load_data  = word;
            store_word = wdata;
            misalign   = (addr_lo != 2'b00);
         end
         default: begin
            load_data = '0;
         end
      endcase
   end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder for the RISC-V load/store port.
// Accepts one request at a time, waits LATENCY cycles, then performs the
// RV32I byte/halfword/word access and returns a one-cycle response.
// Ports:
//   clk         in  1   clock, all state updates on rising edge
//   reset       in  1   synchronous active-high reset
//   req_valid   in  1   request present
//   req_ready   out 1   responder can accept (IDLE only)
//   req_write   in  1   1 = store, 0 = load
//   req_funct3  in  3   RV32I funct3
//   req_addr    in  32  byte address
//   req_wdata   in  32  store data
//   resp_valid  out 1   one-cycle response pulse
//   resp_rdata  out 32  extended load data, 0 for stores/errors
//   resp_error  out 1   misaligned, out-of-range or illegal funct3
module data_memory_responder
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAST_WAIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

   logic [31:0] memory [DEPTH];

   state_t      state;
   state_t      next_state;
   logic [3:0]  wait_cnt;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [2:0]  cap_funct3;
   logic        cap_write;

   logic        accept;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [2:0]  sel_funct3;
   logic        sel_write;
   logic        in_range;
   logic [IW-1:0] sel_index;
   logic [31:0] cur_word;
   logic [31:0] load_data;
   logic [31:0] store_word;
   logic        misalign;
   logic        sel_error;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   // With zero wait states the response is formed on the accept edge itself,
   // before the capture registers hold the request, so in IDLE the live
   // request inputs feed the access path; otherwise the captured copy does.
   always_comb begin
      if (state == IDLE) begin
         sel_addr   = req_addr;
         sel_wdata  = req_wdata;
         sel_funct3 = req_funct3;
         sel_write  = req_write;
      end else begin
         sel_addr   = cap_addr;
         sel_wdata  = cap_wdata;
         sel_funct3 = cap_funct3;
         sel_write  = cap_write;
      end
   end

   // Out-of-range addresses never index the array; their word reads as 0
   // and the error flag suppresses both load data and store commit.
   always_comb begin
      in_range  = (sel_addr[31:2] < 30'(DEPTH));
      sel_index = sel_addr[IW+1:2];
      cur_word  = in_range ? memory[sel_index] : '0;
   end

   mem_lane_align u_align (
      .word       (cur_word),
      .addr_lo    (sel_addr[1:0]),
      .funct3     (sel_funct3),
      .wdata      (sel_wdata),
      .load_data  (load_data),
      .store_word (store_word),
      .misalign   (misalign)
   );

   assign sel_error = misalign || !in_range || f3_illegal(sel_funct3, sel_write);

   // Next-state logic: WAIT is skipped entirely when LATENCY is zero, and
   // RESP always lasts exactly one cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (LATENCY == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == LAST_WAIT) begin
               next_state = RESP;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State, capture and response registers. The response outputs are loaded
   // on the edge that enters RESP so they are valid for exactly that cycle
   // and return to zero on the edge that leaves it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         cap_funct3 <= '0;
         cap_write  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_error <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cap_funct3 <= req_funct3;
            cap_write  <= req_write;
            wait_cnt   <= 4'd0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
         resp_valid <= (next_state == RESP);
         resp_error <= (next_state == RESP) && sel_error;
         resp_rdata <= ((next_state == RESP) && !sel_write && !sel_error) ? load_data : '0;
      end
   end

   // Stores commit on the edge that ends RESP, so a reset during the
   // transaction discards the write and a following load sees the new data.
   always_ff @(posedge clk) begin
      if (!reset && (state == RESP) && cap_write && !resp_error) begin
         memory[sel_index] <= store_word;
      end
   end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder for the RISC-V datapath. It is the slave end of the load/store port: it accepts one request at a time from the core's memory stage over a valid/ready handshake. It inserts a programmable number of wait states, then performs the RV32I byte, halfword or word access and returns one response pulse. It replaces the zero-latency data memory when the core runs with a stalling memory stage.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words in the backing array `memory`; word index = addr[31:2].
- LATENCY, 2: wait-state cycles between request acceptance and the response cycle; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/halfword used for SB/SH.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid: misaligned, out-of-range or illegal funct3.

## Operation
- Request is accepted on a rising edge where req_valid && req_ready; addr, funct3, write, wdata are captured into internal registers. Inputs are don't-care at all other times.
- FSM states and transitions:
  - IDLE → WAIT on accept with LATENCY>0.
  - IDLE → RESP on accept with LATENCY=0.
  - WAIT → RESP when the wait counter reaches LATENCY−1. The counter is 4 bits, cleared on accept.
  - RESP → IDLE unconditionally.
- RESP cycle:
  - resp_valid=1.
  - A store commits to `memory` at the edge ending RESP.
  - A load drives resp_rdata from the array content at the start of RESP.
- Byte lanes are little-endian. addr[1:0] selects the byte, addr[1] selects the halfword.
- LB/LH sign-extend; LBU/LHU zero-extend.
- SB/SH modify only the addressed lanes; other lanes are preserved.
- Error conditions: halfword access with addr[0]=1; word access with addr[1:0]≠0; addr[31:2] ≥ DEPTH; funct3 ∈ {3,6,7}; store with funct3 4 or 5.
- On error: resp_error=1, resp_rdata=0, no array write.
- No response backpressure: the requester must take resp_valid when it is asserted.
- Reset:
  - Outputs reset to req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0; FSM returns to IDLE.
  - Reset during WAIT/RESP discards the transaction. A store discarded this way never commits.
  - `memory` is not cleared by reset; it is loaded by $readmemb from the bench.
- resp_rdata and resp_error are registered. They are 0 outside the response cycle.

## Timing
- Accept edge E0.
- resp_valid is high in the cycle following edge E0+LATENCY. For LATENCY=0 that is the cycle immediately after E0.
- req_ready is low from E0 until the edge that ends RESP.
- Next accept is possible at the edge after RESP ends. Throughput is one transaction per LATENCY+2 cycles.
- Back-to-back store-then-load to the same word: the load observes the stored data, because the store commits before the next accept.
- req_valid held high across a response is accepted again in the first IDLE cycle, with no bubble beyond the state above.

## Structure
- Shared package riscv_mem_pkg:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - FSM state encoding IDLE/WAIT/RESP.
- Sub-module mem_lane_align (combinational):
  - Inputs: stored word, addr[1:0], funct3, wdata.
  - Outputs: extended load data, merged store word, misalign flag.
- The top level holds the FSM, wait counter, capture registers and the `memory` array.

## Test plan
- LATENCY=2, memory[4]=0x8899AABB, LW addr 0x10 → resp_valid in cycle after E0+2, rdata=0x8899AABB, error=0.
- LB addr 0x13 → 0xFFFFFF88; LBU addr 0x13 → 0x00000088; LH addr 0x12 → 0xFFFF8899.
- SB wdata=0x123456CC to addr 0x11, then LW 0x10 → 0x8899CCBB; SH 0x5A5A to addr 0x12, then LW 0x10 → 0x5A5ACCBB.
- Faults, each giving resp_error=1, rdata=0, memory[4] unchanged:
  - LW addr 0x12.
  - SH addr 0x11.
  - LW addr 4·DEPTH.
  - funct3=3.
- Reset asserted during WAIT of SW 0xDEADBEEF to 0x20 → no resp_valid, memory[8] unchanged, req_ready=1 the cycle after reset.
- LATENCY=0, req_valid held high with four LW requests → one resp_valid every 2 cycles, correct data order.
